mult: RTL and testbench
=======================

Name: mult

Overview:
- Sequential signed multiplier, radix-2 Booth. Companion to the multi-cycle divider in the CPU datapath.
- Loads two operands on a one-cycle start pulse, runs one Booth iteration per clock, and writes the 2×WIDTH-bit product to hi/lo, like MIPS MULT.
- hi/lo hold their value until the next multiplication completes, so the datapath reads them with MFHI/MFLO-style moves.

Parameters:
- WIDTH, 32, operand width. hi and lo are each WIDTH bits. One iteration per operand bit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- srcA  input  WIDTH  multiplicand, two's complement.
- srcB  input  WIDTH  multiplier, two's complement.
- multCtrl  input  1  start pulse (MultInit). Operands are sampled on the edge where it is 1.
- busy  output  1  high while iterations are in progress.
- done  output  1  one-cycle pulse in the cycle after hi/lo are updated.
- hi  output  WIDTH  upper half of the signed product.
- lo  output  WIDTH  lower half of the signed product.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Internal accumulator, multiplier register, q_-1 bit and counter cleared.
- States:
  - IDLE: waits for multCtrl=1.
  - RUN: performs iterations.
  - FINISH: lasts one cycle, done=1.
- Load (any state, multCtrl=1 on edge E):
  - M = srcA, sign-extended to WIDTH+1.
  - A = 0 (WIDTH+1 bits). Q = srcB. q_-1 = 0. count = 0.
  - state=RUN, busy=1, done=0.
  - multCtrl in RUN or FINISH restarts the operation with new operands. The aborted result is discarded and hi/lo are unchanged.
- Iteration (RUN, multCtrl=0), per edge, on the pair {Q[0], q_-1}:
  - 01: A = A + M.
  - 10: A = A − M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A, Q, q_-1} by 1. The MSB of A is replicated.
  - count increments.
- Accumulator width: A is WIDTH+1 bits so that A−M cannot overflow when M = −2^(WIDTH−1).
- Completion: on the edge performing iteration WIDTH (count = WIDTH−1 before the edge):
  - hi = A[WIDTH−1:0] after the shift; lo = Q after the shift.
  - state=FINISH, busy=0, done=1.
- Latency:
  - multCtrl at edge E; hi/lo valid and done=1 after edge E+WIDTH (E+32 by default).
  - busy is high after edges E through E+WIDTH−1.
- FINISH to IDLE on the next edge, done=0. multCtrl in FINISH is handled as a load, with done=0.
- Outputs are fully registered. No combinational path from inputs to outputs.
- Boundary cases:
  - Zero operand: completes normally with hi=lo=0. No early exit; latency is fixed.
  - multCtrl held high for several cycles: reloads each edge. Iteration starts on the first edge with multCtrl=0.
  - Reset mid-operation aborts immediately. hi/lo return to 0.
  - Counter width is clog2(WIDTH)+1. Counter wrap cannot occur because RUN exits at WIDTH.

Decomposition:
- Package mult_pkg:
  - state enum {IDLE, RUN, FINISH}.
  - Function for counter width, clog2(WIDTH)+1.
  - Booth select encoding constants (ADD, SUB, NOP).
- One natural sub-module, mult_booth_step. Purely combinational.
  - Inputs: A, Q, q_-1, M.
  - Outputs: shifted {A, Q, q_-1}.
  - The top holds the state machine, counter and registers.

Test Plan:
- 3 × 5, pulse multCtrl -> busy high 32 cycles; after edge E+32: hi=0x00000000, lo=0x0000000F, done=1 for one cycle.
- −7 (0xFFFFFFF9) × 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000 (accumulator-width check). 0xFFFFFFFF × 0xFFFFFFFF -> hi=0, lo=1.
- 0x7FFFFFFF × 0x80000000 -> hi=0xC0000000, lo=0x80000000.
- Start 3×5, then assert multCtrl with 2×2 at iteration 10 -> the first result is never written; done comes 32 edges after the second pulse with hi=0, lo=4.
- Start 9×9, drive reset=0 mid-iteration (between clock edges) -> busy, done, hi and lo go to 0 immediately without a clock edge; after release, IDLE and no done pulse.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } mult_state_e;

   // Booth select is {Q[0], q_-1}
   localparam logic [1:0] BOOTH_NOP = 2'b00;
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: add/sub M, then arithmetic shift of {A,Q,q-1}.
module mult_booth_step
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             qm1_i,
   input  logic [WIDTH:0]   m_i,
   output logic [WIDTH:0]   a_o,
   output logic [WIDTH-1:0] q_o,
   output logic             qm1_o
);

   logic [1:0]     sel;
   logic [WIDTH:0] sum;

   assign sel = {q_i[0], qm1_i};

   always_comb begin
      sum = a_i;
      unique case (sel)
         BOOTH_ADD: sum = a_i + m_i;
         BOOTH_SUB: sum = a_i - m_i;
         BOOTH_NOP: sum = a_i;
         default:   sum = a_i;
      endcase
   end

   assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
   assign q_o   = {sum[0], q_i[WIDTH-1:1]};
   assign qm1_o = q_i[0];

endmodule

// File: rtl/mult.sv
// Sequential signed multiplier, one Booth iteration per clock, MIPS-style hi/lo.
module mult
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             multCtrl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mult_state_e      state_q, state_d;
   logic [WIDTH:0]   a_q, a_d, m_q, m_d;
   logic [WIDTH-1:0] q_q, q_d, hi_q, hi_d, lo_q, lo_d;
   logic             qm1_q, qm1_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH:0]   step_a;
   logic [WIDTH-1:0] step_q;
   logic             step_qm1;
   logic             last;

   mult_booth_step #(.WIDTH(WIDTH)) u_step (
      .a_i   (a_q),
      .q_i   (q_q),
      .qm1_i (qm1_q),
      .m_i   (m_q),
      .a_o   (step_a),
      .q_o   (step_q),
      .qm1_o (step_qm1)
   );

   assign last = (cnt_q == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (multCtrl) state_d = RUN;
         RUN:     if (multCtrl) state_d = RUN;
                  else if (last) state_d = FINISH;
         FINISH:  state_d = multCtrl ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A load in any state discards the in-flight operation
   always_comb begin
      a_d   = a_q;
      m_d   = m_q;
      q_d   = q_q;
      qm1_d = qm1_q;
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (multCtrl) begin
         a_d   = '0;
         m_d   = {srcA[WIDTH-1], srcA};
         q_d   = srcB;
         qm1_d = 1'b0;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         a_d   = step_a;
         q_d   = step_q;
         qm1_d = step_qm1;
         cnt_d = cnt_q + 1'b1;
         if (last) begin
            hi_d = step_a[WIDTH-1:0];
            lo_d = step_q;
         end
      end
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == FINISH);
      hi   = hi_q;
      lo   = lo_q;
   end

endmodule

// File: tb/tb_mult.sv
// Directed self-checking bench for the Booth multiplier.
module tb_mult;

   logic        clk;
   logic        reset;
   logic [31:0] srcA, srcB;
   logic        multCtrl;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_vec;
   int n_err;
   int bad;
   logic [63:0] prev;

   mult #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .srcA     (srcA),
      .srcB     (srcB),
      .multCtrl (multCtrl),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called #1 after load edge E with multCtrl already low
   task automatic finish_chk(input string tag, input logic [63:0] exp);
      chk({tag, "_busy0"}, {63'd0, busy}, 64'd1);
      bad = 0;
      repeat (31) begin
         @(posedge clk); #1;
         if (!busy || done) bad++;
      end
      chk({tag, "_busyrun"}, 64'(bad), 64'd0);
      @(posedge clk); #1;
      chk({tag, "_done"}, {62'd0, done, busy}, 64'd2);
      chk({tag, "_hilo"}, {hi, lo}, exp);
      @(posedge clk); #1;
      chk({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
   endtask

   task automatic run(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp);
      srcA = a;
      srcB = b;
      multCtrl = 1'b1;
      @(posedge clk); #1;
      multCtrl = 1'b0;
      finish_chk(tag, exp);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      multCtrl = 1'b0;
      srcA = '0;
      srcB = '0;
      #12;
      chk("reset", {hi, lo}, 64'd0);
      chk("reset_ctl", {62'd0, done, busy}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      run("3x5", 32'd3, 32'd5, 64'h00000000_0000000F);
      run("0x12345", 32'd0, 32'd12345, 64'd0);
      run("m7x6", 32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6);
      run("minxmin", 32'h80000000, 32'h80000000,
          64'h40000000_00000000);
      run("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
      run("maxxmin", 32'h7FFFFFFF, 32'h80000000,
          64'hC0000000_80000000);

      // Restart at iteration 10 with 2x2
      prev = {hi, lo};
      srcA = 32'd3;
      srcB = 32'd5;
      multCtrl = 1'b1;
      @(posedge clk); #1;
      multCtrl = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      srcA = 32'd2;
      srcB = 32'd2;
      multCtrl = 1'b1;
      @(posedge clk); #1;
      multCtrl = 1'b0;
      bad = 0;
      for (int i = 0; i < 31; i++) begin
         @(posedge clk); #1;
         if (done || {hi, lo} !== prev) bad++;
      end
      chk("restart_hold", 64'(bad), 64'd0);
      @(posedge clk); #1;
      chk("restart_done", {63'd0, done}, 64'd1);
      chk("restart_hilo", {hi, lo}, 64'd4);
      @(posedge clk); #1;

      // multCtrl held for three edges: last load wins
      multCtrl = 1'b1;
      srcA = 32'd100;
      srcB = 32'd7;
      @(posedge clk); #1;
      srcA = 32'd5;
      srcB = 32'd9;
      @(posedge clk); #1;
      srcA = 32'd4;
      srcB = 32'hFFFFFFFD;
      @(posedge clk); #1;
      multCtrl = 1'b0;
      finish_chk("hold", 64'hFFFFFFFF_FFFFFFF4);

      // Asynchronous reset mid-operation
      srcA = 32'd9;
      srcB = 32'd9;
      multCtrl = 1'b1;
      @(posedge clk); #1;
      multCtrl = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_ctl", {62'd0, done, busy}, 64'd0);
      chk("arst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) bad++;
      end
      chk("arst_after", 64'(bad), 64'd0);
      chk("arst_after_hilo", {hi, lo}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
